// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, reads MemoriaInstrucao and hands {pc, instr} to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise erro_alinhamento and park in PARADO.
module busca_instrucao #(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter int          ENDR_W   = 7,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ENDR_W-1:0] endr,
    input  logic [31:0]       instr_mem,
    input  logic              desvio,
    input  logic [63:0]       alvo,
    output logic              valid,
    input  logic              pronto,
    output logic [31:0]       instr,
    output logic [63:0]       pc,
    output logic              erro_alinhamento,
    output logic              estado_dbg
);

    // Handshake: a head entry transfers at a rising edge exactly when valid && pronto;
    // instr/pc hold steady while valid && !pronto, and desvio at the same edge voids the transfer.

    typedef enum logic {
        ATIVO  = 1'b0,
        PARADO = 1'b1
    } estado_t;

    estado_t     estado_q, estado_d;

    logic [63:0] pc_req_q, pc_req_d;
    logic [63:0] tag_q, tag_d;
    logic        em_voo_q, em_voo_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [63:0] buf_pc_q  [2];
    logic [31:0] buf_ins_q [2];

    logic        ativo;
    logic        push;
    logic        pop;
    logic        buf_we;
    logic        emite;
    logic [1:0]  ocup_pos;
    logic [63:0] alvo_ef;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        desalinhado;
    logic        erro_q, erro_d;

    assign desalinhado = (alvo[1:0] != 2'b00);
    assign alvo_ef     = alvo;
`else
    logic        unused_alvo_lsb;

    assign unused_alvo_lsb = ^alvo[1:0];
    assign alvo_ef         = {alvo[63:2], 2'b00};
`endif

    assign ativo = (estado_q == ATIVO);
    assign push  = em_voo_q;
    assign pop   = valid && pronto;

    // A pop at this edge frees its slot, so the credit check uses post-pop occupancy;
    // this keeps one instruction per cycle when pronto stays high.
    assign ocup_pos = cnt_q - {1'b0, pop};
    assign emite    = ativo && !desvio && ((ocup_pos + {1'b0, em_voo_q}) < 2'd2);

    assign endr = pc_req_q[ENDR_W+1:2];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ATIVO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        estado_d = estado_q;
`ifdef FETCH_ALIGN_CHECK_EN
        if (estado_q == ATIVO && desvio && desalinhado) begin
            estado_d = PARADO;
        end
`endif
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        valid      = ativo && (cnt_q != 2'd0);
        instr      = NOP;
        pc         = 64'h0;
        estado_dbg = estado_q;
        if (valid) begin
            instr = buf_ins_q[rd_ptr_q];
            pc    = buf_pc_q[rd_ptr_q];
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign erro_d           = erro_q || (desvio && desalinhado);
    assign erro_alinhamento = erro_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end
`else
    assign erro_alinhamento = 1'b0;
`endif

    // ---------------- fetch pointer, in-flight tag and buffer control ----------------
    always_comb begin
        pc_req_d = pc_req_q;
        tag_d    = tag_q;
        em_voo_d = em_voo_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        buf_we   = 1'b0;
        if (desvio) begin
            // Redirect wins: drop buffered words and the word still in the memory pipe.
            pc_req_d = alvo_ef;
            em_voo_d = 1'b0;
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            em_voo_d = emite;
            if (emite) begin
                tag_d    = pc_req_q;
                pc_req_d = pc_req_q + 64'd4;
            end
            if (push) begin
                buf_we   = 1'b1;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_req_q <= PC_RESET;
            tag_q    <= 64'h0;
            em_voo_q <= 1'b0;
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            pc_req_q <= pc_req_d;
            tag_q    <= tag_d;
            em_voo_q <= em_voo_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]  <= 64'h0;
                buf_ins_q[i] <= 32'h0;
            end
        end else if (buf_we) begin
            buf_pc_q[wr_ptr_q]  <= tag_q;
            buf_ins_q[wr_ptr_q] <= instr_mem;
        end
    end

endmodule
